dp_convert_iter: RTL and testbench
==================================

# dp_convert_iter

Multi-cycle converter from IEEE-754 binary64 to binary32, INT32 or UINT32, with IEEE rounding and exception flags. It is the narrowing counterpart of the FP32/INT32/UINT32 → FP64 widening converter in the FPU. It sits behind the FPU issue stage on a valid/ready handshake. Alignment is iterative, using a bounded right-shifter, so the block trades latency for area.

## Interface
- SHIFT_STEP, 8: maximum right-shift distance applied per ALIGN cycle; legal range 1–56.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand and controls are valid.
- in_ready  out  1  block can accept; high only in IDLE.
- operand_in  in  64  binary64 operand.
- output_type  in  2  target type: 00 FP32, 10 INT32, 11 UINT32; 01 is reserved.
- rounding_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes behave as RTZ.
- out_valid  out  1  result and flags are valid; held until out_ready.
- out_ready  in  1  consumer accepts the result.
- result  out  32  converted value; an integer result is two's complement.
- flag_invalid, flag_overflow, flag_underflow, flag_inexact  out  1 each  exception flags, valid with out_valid.

## Operation
- FSM states: IDLE, ALIGN, ROUND, DONE.
- IDLE → capture on in_valid & in_ready. Latch sign, exp[10:0] and a 53-bit significand; the hidden bit is 0 when exp=0, in which case exp is treated as 1.
- Work register W[55:0] = {sig53, G, R, S}. Bits shifted past S are OR-ed into S.
- Special inputs go from capture directly to DONE:
  - NaN → FP32: 0x7FC00000; NV only if signalling (frac[51]=0).
  - NaN → INT32: 0x7FFFFFFF, NV. NaN → UINT32: 0xFFFFFFFF, NV.
  - ±Inf → FP32: ±Inf, no flags.
  - ±Inf → INT32 saturates to 0x7FFFFFFF / 0x80000000. ±Inf → UINT32 saturates to 0xFFFFFFFF / 0. Both raise NV.
  - ±0 → FP32: ±0. ±0 → integer: 0. No flags.
  - exp > 1054 for an integer target: saturate per sign as for Inf, NV.
  - exp ≥ 1151 for FP32: take the overflow response below.
  - Reserved output_type: result 0, NV.
- Total right shift N:
  - FP32, exp ≥ 897 (normal): N = 29.
  - FP32, exp < 897 (tiny): N = 29 + (897 − exp).
  - Integer targets: N = 1075 − exp.
  - N saturates at 56.
- ALIGN shifts W right by min(remaining, SHIFT_STEP) per cycle until remaining = 0. There is always at least one ALIGN cycle.
- ROUND: kept = W[55:3]. Round up when:
  - RNE: G&(lsb|R|S).
  - RMM: G.
  - RUP: (G|R|S)&~sign.
  - RDN: (G|R|S)&sign.
  - RTZ: never.
  - NX = G|R|S.
- FP32 normal path:
  - Biased exp = exp − 896.
  - A carry to 2^24 increments the exponent.
  - Exponent reaching 255 is overflow, with OF and NX set. Result is ±Inf, except max finite ±0x7F7FFFFF for RTZ, for RDN with a positive value and for RUP with a negative value.
- FP32 tiny path: result exponent is 0, or 1 if rounding carries into 2^23. UF = NX (tininess detected before rounding).
- Integer paths:
  - Apply the sign after rounding.
  - INT32 magnitude > 2^31−1 positive or > 2^31 negative → saturate, NV.
  - UINT32 with a negative nonzero rounded result → 0, NV. With a result > 0xFFFFFFFF → 0xFFFFFFFF, NV.
  - Whenever NV is set on an integer path, NX=0 and OF=0.
- DONE: out_valid high; result and flags held stable. Return to IDLE on out_ready.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0.
- Accept at cycle T:
  - Specials: out_valid at T+1.
  - Normal: out_valid at T+A+2, where A = max(1, ceil(N/SHIFT_STEP)).
- With SHIFT_STEP=8: FP32 normal output (N=29) arrives at T+6.
- No overlap between operations. in_ready rises the cycle after the out handshake. The earliest next accept is 1 cycle after out_valid falls.
- out_ready may be high before out_valid; the handshake completes in the first DONE cycle.
- rst_n asserted in any state aborts the operation: no result is produced and the outputs return to reset values immediately.
- Inputs are sampled only in the accept cycle; later changes are ignored.

## Configuration
- DP_CVT_BARREL_EN defined: ALIGN performs the full N-bit shift in one cycle, so A=1 always (normal latency T+3) and SHIFT_STEP is ignored.
- Undefined: iterative shifting as specified above.

## Test plan
- 0x3FF0000000000000 → FP32, RNE, SHIFT_STEP=8 → 0x3F800000, no flags, out_valid at T+6 (T+3 with DP_CVT_BARREL_EN).
- 0x3FF0000010000000 (1+2^-24 tie) → FP32: RNE → 0x3F800000 NX; RUP → 0x3F800001 NX.
- 0xC004000000000000 (−2.5) → INT32: RNE → 0xFFFFFFFE NX; RMM → 0xFFFFFFFD NX. 0x36A0000000000000 (2^-149) → FP32 → 0x00000001, no flags.
- 0x41E0000000000000 (2^31): → INT32 gives 0x7FFFFFFF NV; → UINT32 gives 0x80000000, no flags. 0xC1E0000000000000 → INT32 → 0x80000000, no flags.
- 0x7FEFFFFFFFFFFFFF → FP32: RNE → 0x7F800000 OF NX; RTZ → 0x7F7FFFFF OF NX. 0x7FF0000000000001 → FP32 → 0x7FC00000 NV.
- Hold out_ready low 5 cycles in DONE → result, flags and out_valid stable, in_ready=0. Assert rst_n low during ALIGN → out_valid=0, in_ready=1, no output produced.

Source files
------------

// File: rtl/dp_convert_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dp_convert_iter                                               |
// | Purpose  : Multi-cycle binary64 -> FP32 / INT32 / UINT32 converter with  |
// |            IEEE rounding and exception flags. A bounded right-shifter    |
// |            aligns the significand over several cycles.                   |
// | Params   : SHIFT_STEP - max right-shift distance per ALIGN cycle (1..56) |
// | Macro    : DP_CVT_BARREL_EN - align in one cycle (full N-bit shift)     |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            in_valid/in_ready, operand_in[63:0], output_type[1:0],        |
// |            rounding_mode[2:0] - request side                             |
// |            out_valid/out_ready, result[31:0], flag_invalid,              |
// |            flag_overflow, flag_underflow, flag_inexact - response side   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dp_convert_iter #(
   parameter int SHIFT_STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] operand_in,
   input  logic [1:0]  output_type,
   input  logic [2:0]  rounding_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        flag_invalid,
   output logic        flag_overflow,
   output logic        flag_underflow,
   output logic        flag_inexact
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] c_rne = 3'd0;
   localparam logic [2:0] c_rdn = 3'd2;
   localparam logic [2:0] c_rup = 3'd3;
   localparam logic [2:0] c_rmm = 3'd4;

   state_t      r_state;
   logic        r_in_ready, r_out_valid;
   logic [31:0] r_result;
   logic [3:0]  r_flags;          // {NV, OF, UF, NX}
   logic        r_sign, r_tiny;
   logic [10:0] r_exp;
   logic [1:0]  r_type;
   logic [2:0]  r_rm;
   logic [55:0] r_work;           // {sig53, G, R, S}
   logic [5:0]  r_rem;

   // Overflow response: max finite magnitude when rounding toward zero for
   // this sign, infinity otherwise. Unlisted modes behave as RTZ.
   function automatic logic [31:0] fp32_ovf(input logic sign, input logic [2:0] rm);
      logic to_inf;
      to_inf = (rm == c_rne) || (rm == c_rmm) || ((rm == c_rdn) && sign) ||
               ((rm == c_rup) && !sign);
      return to_inf ? {sign, 8'hFF, 23'd0} : {sign, 31'h7F7F_FFFF};
   endfunction

   function automatic logic [31:0] sat_int(input logic sign, input logic uns);
      if (uns) return sign ? 32'h0000_0000 : 32'hFFFF_FFFF;
      else     return sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
   endfunction

   // ---------------- capture-side decode ----------------
   logic        w_sign, w_fp32, w_rsvd, w_uns;
   logic [10:0] w_exp, w_exp_eff;
   logic [51:0] w_frac;
   logic [52:0] w_sig;
   logic        w_is_nan, w_is_inf, w_is_zero;
   logic [11:0] w_n_raw;
   logic [5:0]  w_n;

   assign w_sign    = operand_in[63];
   assign w_exp     = operand_in[62:52];
   assign w_frac    = operand_in[51:0];
   assign w_exp_eff = (w_exp == 11'd0) ? 11'd1 : w_exp;
   assign w_sig     = {(w_exp != 11'd0), w_frac};
   assign w_is_nan  = (&w_exp) && (|w_frac);
   assign w_is_inf  = (&w_exp) && !(|w_frac);
   assign w_is_zero = (w_exp == 11'd0) && !(|w_frac);
   assign w_fp32    = (output_type == 2'b00);
   assign w_rsvd    = (output_type == 2'b01);
   assign w_uns     = output_type[0];

   // Total alignment distance; anything beyond 56 lands entirely in sticky.
   always_comb begin
      if (w_fp32)
         w_n_raw = (w_exp_eff >= 11'd897) ? 12'd29 : (12'd926 - {1'b0, w_exp_eff});
      else
         w_n_raw = 12'd1075 - {1'b0, w_exp_eff};
   end
   assign w_n = (w_n_raw > 12'd56) ? 6'd56 : w_n_raw[5:0];

   logic        w_special;
   logic [31:0] w_sp_result;
   logic [3:0]  w_sp_flags;

   always_comb begin
      w_special   = 1'b1;
      w_sp_result = 32'd0;
      w_sp_flags  = 4'b0000;
      if (w_rsvd) begin
         w_sp_flags = 4'b1000;
      end else if (w_is_nan) begin
         if (w_fp32) begin
            w_sp_result = 32'h7FC0_0000;
            w_sp_flags  = {~w_frac[51], 3'b000};
         end else begin
            w_sp_result = w_uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            w_sp_flags  = 4'b1000;
         end
      end else if (w_is_inf) begin
         if (w_fp32) begin
            w_sp_result = {w_sign, 8'hFF, 23'd0};
         end else begin
            w_sp_result = sat_int(w_sign, w_uns);
            w_sp_flags  = 4'b1000;
         end
      end else if (w_is_zero) begin
         w_sp_result = w_fp32 ? {w_sign, 31'd0} : 32'd0;
      end else if (!w_fp32 && (w_exp > 11'd1054)) begin
         w_sp_result = sat_int(w_sign, w_uns);
         w_sp_flags  = 4'b1000;
      end else if (w_fp32 && (w_exp >= 11'd1151)) begin
         w_sp_result = fp32_ovf(w_sign, rounding_mode);
         w_sp_flags  = 4'b0101;
      end else begin
         w_special = 1'b0;
      end
   end

   // ---------------- alignment step ----------------
   logic [5:0]  w_amt;
   logic [55:0] w_shifted;
   logic        w_lost;

`ifdef DP_CVT_BARREL_EN
   assign w_amt = r_rem;
`else
   localparam logic [5:0] c_step = 6'(SHIFT_STEP);
   assign w_amt = (r_rem > c_step) ? c_step : r_rem;
`endif

   assign w_shifted = r_work >> w_amt;
   // Bits pushed out below the new S position collapse into S.
   assign w_lost    = |(r_work & ~({56{1'b1}} << w_amt));

   // ---------------- rounding ----------------
   logic [52:0] w_kept;
   logic        w_g, w_r, w_s, w_nx, w_up;
   logic [53:0] w_rnd;
   logic [11:0] w_bexp;
   logic [31:0] w_rd_result;
   logic [3:0]  w_rd_flags;

   assign w_kept = r_work[55:3];
   assign w_g    = r_work[2];
   assign w_r    = r_work[1];
   assign w_s    = r_work[0];
   assign w_nx   = w_g | w_r | w_s;

   always_comb begin
      case (r_rm)
         c_rne:   w_up = w_g & (w_kept[0] | w_r | w_s);
         c_rmm:   w_up = w_g;
         c_rup:   w_up = w_nx & ~r_sign;
         c_rdn:   w_up = w_nx & r_sign;
         default: w_up = 1'b0;
      endcase
   end

   assign w_rnd  = {1'b0, w_kept} + {53'd0, w_up};
   // A carry out of the 24-bit significand bumps the exponent.
   assign w_bexp = {1'b0, r_exp} - 12'd896 + {11'd0, w_rnd[24]};

   always_comb begin
      w_rd_result = 32'd0;
      w_rd_flags  = {3'b000, w_nx};
      if (r_type == 2'b00) begin
         if (r_tiny) begin
            // Carry into bit 23 naturally yields biased exponent 1.
            w_rd_result = {r_sign, 7'd0, w_rnd[23:0]};
            w_rd_flags  = {2'b00, w_nx, w_nx};
         end else if (w_bexp >= 12'd255) begin
            w_rd_result = fp32_ovf(r_sign, r_rm);
            w_rd_flags  = 4'b0101;
         end else begin
            w_rd_result = {r_sign, w_bexp[7:0], w_rnd[22:0]};
         end
      end else if (!r_type[0]) begin
         if (r_sign ? (w_rnd > 54'h0_8000_0000) : (w_rnd > 54'h0_7FFF_FFFF)) begin
            w_rd_result = sat_int(r_sign, 1'b0);
            w_rd_flags  = 4'b1000;
         end else begin
            w_rd_result = r_sign ? (32'd0 - w_rnd[31:0]) : w_rnd[31:0];
         end
      end else begin
         if (r_sign && (w_rnd != 54'd0)) begin
            w_rd_result = 32'd0;
            w_rd_flags  = 4'b1000;
         end else if (w_rnd > 54'h0_FFFF_FFFF) begin
            w_rd_result = 32'hFFFF_FFFF;
            w_rd_flags  = 4'b1000;
         end else begin
            w_rd_result = w_rnd[31:0];
         end
      end
   end

   // ---------------- control ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= 32'd0;
         r_flags     <= 4'b0000;
         r_sign      <= 1'b0;
         r_tiny      <= 1'b0;
         r_exp       <= 11'd0;
         r_type      <= 2'b00;
         r_rm        <= 3'd0;
         r_work      <= 56'd0;
         r_rem       <= 6'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  r_sign     <= w_sign;
                  r_exp      <= w_exp_eff;
                  r_type     <= output_type;
                  r_rm       <= rounding_mode;
                  r_tiny     <= w_fp32 && (w_exp_eff < 11'd897);
                  r_work     <= {w_sig, 3'b000};
                  r_rem      <= w_n;
                  if (w_special) begin
                     r_result    <= w_sp_result;
                     r_flags     <= w_sp_flags;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_state <= ST_ALIGN;
                  end
               end
            end
            ST_ALIGN: begin
               r_work <= {w_shifted[55:1], w_shifted[0] | w_lost};
               r_rem  <= r_rem - w_amt;
               if (r_rem == w_amt) r_state <= ST_ROUND;
            end
            ST_ROUND: begin
               r_result    <= w_rd_result;
               r_flags     <= w_rd_flags;
               r_out_valid <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready       = r_in_ready;
   assign out_valid      = r_out_valid;
   assign result         = r_result;
   assign flag_invalid   = r_flags[3];
   assign flag_overflow  = r_flags[2];
   assign flag_underflow = r_flags[1];
   assign flag_inexact   = r_flags[0];

endmodule
`default_nettype wire

// File: tb/tb_dp_convert_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dp_convert_iter                                            |
// | Purpose  : Self-checking bench for dp_convert_iter: exact-arithmetic     |
// |            reference model, scoreboard compare each output cycle,        |
// |            directed vectors with hand-computed pins, latency and reset.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dp_convert_iter;
   localparam int SHIFT_STEP = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] operand_in = 64'd0;
   logic [1:0]  output_type = 2'b00;
   logic [2:0]  rounding_mode = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;
   logic [3:0]  dut_flags;

   assign dut_flags = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};

   always #5 clk = ~clk;

   dp_convert_iter #(.SHIFT_STEP(SHIFT_STEP)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .operand_in(operand_in), .output_type(output_type), .rounding_mode(rounding_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result),
      .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
      .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;
   exp_t exp_q[$];

   // ---------------- reference model (exact arithmetic) ----------------
   // Splits m / 2^k into integer quotient q and classifies the discarded
   // fraction against one half.
   function automatic void split(input logic [52:0] m, input int k,
                                 output logic [63:0] q, output int cmp, output bit inx);
      logic [63:0] rem, half;
      if (k >= 60) begin
         q = 64'd0; inx = (m != 53'd0); cmp = -1;
      end else begin
         q    = 64'(m) >> k;
         rem  = 64'(m) & ((64'd1 << k) - 64'd1);
         half = 64'd1 << (k - 1);
         inx  = (rem != 64'd0);
         cmp  = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
      end
   endfunction

   function automatic bit rnd_up(input bit odd, input int cmp, input bit inx,
                                 input bit s, input logic [2:0] rm);
      case (rm)
         3'd0:    return (cmp > 0) || ((cmp == 0) && odd);
         3'd4:    return (cmp >= 0);
         3'd3:    return inx && !s;
         3'd2:    return inx && s;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void model(input logic [63:0] op, input logic [1:0] t, input logic [2:0] rm,
                                 output logic [31:0] res, output logic [3:0] flg, output int lat);
      bit          s, maxfin;
      int          e, ee, n, a, be, cmp;
      logic [51:0] f;
      logic [52:0] m;
      logic [63:0] q;
      bit          inx;
      longint      qr, v;
      logic [31:0] sat, ovf;
      s   = op[63];
      e   = int'(op[62:52]);
      f   = op[51:0];
      ee  = (e == 0) ? 1 : e;
      m   = {(e != 0), f};
      sat = (t == 2'b11) ? (s ? 32'h0 : 32'hFFFF_FFFF) : (s ? 32'h8000_0000 : 32'h7FFF_FFFF);
      maxfin = (rm == 3'd1) || (rm > 3'd4) || ((rm == 3'd2) && !s) || ((rm == 3'd3) && s);
      ovf = maxfin ? {s, 31'h7F7F_FFFF} : {s, 8'hFF, 23'd0};
      res = 32'd0; flg = 4'b0000; lat = 1;
      if (t == 2'b01) begin flg = 4'b1000; return; end
      if (e == 2047 && f != 52'd0) begin
         if (t == 2'b00) begin res = 32'h7FC0_0000; flg = {!f[51], 3'b000}; end
         else begin res = (t == 2'b11) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF; flg = 4'b1000; end
         return;
      end
      if (e == 2047) begin
         if (t == 2'b00) res = {s, 8'hFF, 23'd0};
         else begin res = sat; flg = 4'b1000; end
         return;
      end
      if (e == 0 && f == 52'd0) begin res = (t == 2'b00) ? {s, 31'd0} : 32'd0; return; end
      if (t != 2'b00 && e > 1054) begin res = sat; flg = 4'b1000; return; end
      if (t == 2'b00 && e >= 1151) begin res = ovf; flg = 4'b0101; return; end

      if (t == 2'b00) n = (ee >= 897) ? 29 : 29 + 897 - ee;
      else            n = 1075 - ee;
      a = (n > 56) ? 56 : n;
`ifdef DP_CVT_BARREL_EN
      lat = 3;
`else
      lat = ((a + SHIFT_STEP - 1) / SHIFT_STEP < 1 ? 1 : (a + SHIFT_STEP - 1) / SHIFT_STEP) + 2;
`endif
      split(m, n, q, cmp, inx);
      qr = longint'(q) + longint'(rnd_up(q[0], cmp, inx, s, rm));
      if (t == 2'b00) begin
         if (ee >= 897) begin
            be = ee - 896;
            if (qr == (longint'(1) << 24)) begin qr = longint'(1) << 23; be = be + 1; end
            if (be >= 255) begin res = ovf; flg = 4'b0101; end
            else begin res = {s, 8'(be), 23'(qr)}; flg = {3'b000, inx}; end
         end else begin
            res = {s, 31'(qr)};
            flg = {2'b00, inx, inx};
         end
      end else begin
         v = s ? -qr : qr;
         if (t == 2'b10) begin
            if (v > 64'sd2147483647 || v < -64'sd2147483648) begin res = sat; flg = 4'b1000; end
            else begin res = 32'(v); flg = {3'b000, inx}; end
         end else begin
            if (v < 0)                       begin res = 32'd0;        flg = 4'b1000; end
            else if (v > 64'sd4294967295)    begin res = 32'hFFFF_FFFF; flg = 4'b1000; end
            else begin res = 32'(v); flg = {3'b000, inx}; end
         end
      end
   endfunction

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid result=%h flags=%b", result, dut_flags);
         end else begin
            if (result !== exp_q[0].res || dut_flags !== exp_q[0].flg) begin
               errors++;
               $display("FAIL result_flags got %h/%b want %h/%b",
                        result, dut_flags, exp_q[0].res, exp_q[0].flg);
            end
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_op(input logic [63:0] op, input logic [1:0] t, input logic [2:0] rm,
                         input int hold);
      logic [31:0] er;
      logic [3:0]  ef;
      int          el, lat, guard;
      exp_t        x;
      model(op, t, rm, er, ef, el);
      guard = 0;
      while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL in_ready_wait got %b want 1", in_ready);
      end
      operand_in = op; output_type = t; rounding_mode = rm; in_valid = 1'b1;
      out_ready  = (hold == 0);
      @(posedge clk); #1;
      x.res = er; x.flg = ef;
      exp_q.push_back(x);
      // Scramble inputs after acceptance; the block must ignore them.
      in_valid = 1'b0;
      operand_in = {$urandom, $urandom};
      output_type = 2'($urandom);
      rounding_mode = 3'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != el) begin
         errors++; $display("FAIL latency op=%h got %0d want %0d", op, lat, el);
      end
      if (!out_valid) begin exp_q.delete(); out_ready = 1'b0; return; end
      for (int i = 0; i < hold; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL hold in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL post_handshake out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   // Pin the model against a hand-computed expectation, then run the DUT.
   task automatic pin(input string name, input logic [63:0] op, input logic [1:0] t,
                      input logic [2:0] rm, input logic [31:0] want_res, input logic [3:0] want_flg,
                      input int hold);
      logic [31:0] mr;
      logic [3:0]  mf;
      int          ml;
      model(op, t, rm, mr, mf, ml);
      checks++;
      if (mr !== want_res || mf !== want_flg) begin
         errors++; $display("FAIL pin_%s model %h/%b want %h/%b", name, mr, mf, want_res, want_flg);
      end
      run_op(op, t, rm, hold);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] mr;
      logic [3:0]  mf;
      int          ml, e, cat;
      logic [51:0] f;
      logic [1:0]  t;

      // Reset values while held in reset and just after release.
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || dut_flags !== 4'd0) begin
         errors++; $display("FAIL reset_values in_ready=%b out_valid=%b result=%h flags=%b want 1/0/0/0",
                            in_ready, out_valid, result, dut_flags);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency pin for the 1.0 -> FP32 case.
      model(64'h3FF0_0000_0000_0000, 2'b00, 3'd0, mr, mf, ml);
      checks++;
`ifdef DP_CVT_BARREL_EN
      if (ml != 3) begin errors++; $display("FAIL pin_latency model %0d want 3", ml); end
`else
      if (ml != 6) begin errors++; $display("FAIL pin_latency model %0d want 6", ml); end
`endif

      pin("one_fp32",     64'h3FF0_0000_0000_0000, 2'b00, 3'd0, 32'h3F80_0000, 4'b0000, 5);
      pin("tie_rne",      64'h3FF0_0000_1000_0000, 2'b00, 3'd0, 32'h3F80_0000, 4'b0001, 0);
      pin("tie_rup",      64'h3FF0_0000_1000_0000, 2'b00, 3'd3, 32'h3F80_0001, 4'b0001, 1);
      pin("m2p5_rne",     64'hC004_0000_0000_0000, 2'b10, 3'd0, 32'hFFFF_FFFE, 4'b0001, 0);
      pin("m2p5_rmm",     64'hC004_0000_0000_0000, 2'b10, 3'd4, 32'hFFFF_FFFD, 4'b0001, 2);
      pin("min_denorm",   64'h36A0_0000_0000_0000, 2'b00, 3'd0, 32'h0000_0001, 4'b0000, 0);
      pin("p2_31_int",    64'h41E0_0000_0000_0000, 2'b10, 3'd0, 32'h7FFF_FFFF, 4'b1000, 0);
      pin("p2_31_uint",   64'h41E0_0000_0000_0000, 2'b11, 3'd0, 32'h8000_0000, 4'b0000, 0);
      pin("m2_31_int",    64'hC1E0_0000_0000_0000, 2'b10, 3'd0, 32'h8000_0000, 4'b0000, 0);
      pin("max_rne",      64'h7FEF_FFFF_FFFF_FFFF, 2'b00, 3'd0, 32'h7F80_0000, 4'b0101, 0);
      pin("max_rtz",      64'h7FEF_FFFF_FFFF_FFFF, 2'b00, 3'd1, 32'h7F7F_FFFF, 4'b0101, 1);
      pin("max_rm7",      64'h7FEF_FFFF_FFFF_FFFF, 2'b00, 3'd7, 32'h7F7F_FFFF, 4'b0101, 0);
      pin("snan_fp32",    64'h7FF0_0000_0000_0001, 2'b00, 3'd0, 32'h7FC0_0000, 4'b1000, 0);
      pin("qnan_fp32",    64'h7FF8_0000_0000_0000, 2'b00, 3'd0, 32'h7FC0_0000, 4'b0000, 0);
      pin("ninf_uint",    64'hFFF0_0000_0000_0000, 2'b11, 3'd0, 32'h0000_0000, 4'b1000, 0);
      pin("neg07_uint",   64'hBFE6_6666_6666_6666, 2'b11, 3'd0, 32'h0000_0000, 4'b1000, 0);
      pin("reserved",     64'h3FF0_0000_0000_0000, 2'b01, 3'd0, 32'h0000_0000, 4'b1000, 0);
      pin("f64_den_rup",  64'h0000_0000_0000_0001, 2'b00, 3'd3, 32'h0000_0001, 4'b0011, 0);
      pin("nzero_fp32",   64'h8000_0000_0000_0000, 2'b00, 3'd0, 32'h8000_0000, 4'b0000, 0);

      // Directed sweep across exponent regions, modes and targets.
      for (int i = 0; i < 60; i++) begin
         cat = i % 6;
         case (cat)
            0: e = 860 + int'($urandom_range(0, 300));
            1: e = 1000 + int'($urandom_range(0, 60));
            2: e = 0;
            3: e = 2047;
            4: e = int'($urandom_range(0, 2047));
            default: e = 1020 + int'($urandom_range(0, 10));
         endcase
         f = {$urandom, $urandom};
         if (i % 4 == 1) f[27:0] = 28'd0;
         if (i % 4 == 2) f[27:0] = 28'h800_0000;
         t = (i % 11 == 0) ? 2'b01 : ((i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b10 : 2'b11));
         run_op({1'($urandom), 11'(e), f}, t, 3'(i % 8), i % 3);
      end

      // Reset in the middle of ALIGN aborts the operation.
      operand_in = 64'h3FF0_0000_0000_0000; output_type = 2'b00; rounding_mode = 3'd0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || dut_flags !== 4'd0) begin
         errors++; $display("FAIL abort_reset out_valid=%b in_ready=%b result=%h want 0/1/0",
                            out_valid, in_ready, result);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_no_output out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
         end
      end

      // Normal operation resumes after the abort.
      run_op(64'h4000_0000_0000_0000, 2'b10, 3'd0, 0);
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
